// File: rtl/fpm_arbiter.sv
// rtl/fpm_arbiter.sv - two-requester round-robin front end for a shared pipelined FPM_32 with drain control
module fpm_arbiter #(
    parameter int LAT = 3,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic [31:0]   req0_x,
    input  logic [31:0]   req0_y,
    input  logic [31:0]   req1_x,
    input  logic [31:0]   req1_y,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic [31:0]   fpm_x,
    output logic [31:0]   fpm_y,
    input  logic [31:0]   fpm_m,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [31:0]   rsp_m,
    input  logic          drain_req,
    output logic          drain_done,
    output logic [CW-1:0] issue_cnt0,
    output logic [CW-1:0] issue_cnt1
);

    typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

    state_t         state;
    logic           rr;
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic [LAT-1:0] tag_v_shift;
    logic           run;
    logic           grant0;
    logic           grant1;

    always_comb begin
        run    = (state == RUN) && !reset;
        grant0 = run && req0_valid && (!req1_valid || !rr);
        grant1 = run && req1_valid && (!req0_valid || rr);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign fpm_x      = grant0 ? req0_x : (grant1 ? req1_x : 32'h0);
    assign fpm_y      = grant0 ? req0_y : (grant1 ? req1_y : 32'h0);

    assign rsp0_valid = tag_v[LAT-1] && !tag_id[LAT-1];
    assign rsp1_valid = tag_v[LAT-1] && tag_id[LAT-1];
    assign rsp_m      = tag_v[LAT-1] ? fpm_m : 32'h0;

    // Tag valids as they will look after the next edge while draining (no new issue enters stage 0)
    always_comb begin
        tag_v_shift = '0;
        for (int k = 1; k < LAT; k++) begin
            tag_v_shift[k] = tag_v[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            drain_done <= 1'b0;
            rr         <= 1'b0;
            tag_v      <= '0;
            tag_id     <= '0;
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            tag_v[0]  <= grant0 | grant1;
            tag_id[0] <= grant1;
            for (int k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
            if (grant0) begin
                rr         <= 1'b1;
                issue_cnt0 <= issue_cnt0 + CW'(1);
            end
            if (grant1) begin
                rr         <= 1'b0;
                issue_cnt1 <= issue_cnt1 + CW'(1);
            end
            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (tag_v_shift == '0) begin
                        state      <= DRAINED;
                        drain_done <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_req) begin
                        state      <= RUN;
                        drain_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpm_arbiter.sv
// tb/tb_fpm_arbiter.sv - directed and randomized self-checking bench for fpm_arbiter
module tb_fpm_arbiter;
    localparam int LAT = 3;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0]   req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic          req0_ready, req1_ready;
    logic [31:0]   fpm_x, fpm_y, fpm_m, rsp_m;
    logic          rsp0_valid, rsp1_valid;
    logic          drain_req = 1'b0;
    logic          drain_done;
    logic [CW-1:0] issue_cnt0, issue_cnt1;

    int total = 0;
    int bad   = 0;

    // Stand-in multiplier: fpm_m is x^y of the operands presented LAT cycles earlier, unless overridden
    logic [31:0] fpm_pipe [LAT];
    logic        use_ovr = 1'b0;
    logic [31:0] ovr_m = '0;

    always @(posedge clk) begin
        fpm_pipe[0] <= fpm_x ^ fpm_y;
        for (int k = 1; k < LAT; k++) fpm_pipe[k] <= fpm_pipe[k-1];
    end
    assign fpm_m = use_ovr ? ovr_m : fpm_pipe[LAT-1];

    always #5 clk = ~clk;

    fpm_arbiter #(.LAT(LAT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .fpm_x(fpm_x), .fpm_y(fpm_y), .fpm_m(fpm_m),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_m(rsp_m),
        .drain_req(drain_req), .drain_done(drain_done),
        .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
    endtask

    task automatic do_reset();
        idle();
        drain_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_x = 32'h1234_5678; req1_x = 32'h9abc_def0;
        reset = 1'b1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %b exp 0", req0_ready); end
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %b exp 0", req1_ready); end
        total++; if (fpm_x !== 32'h0) begin bad++; $display("FAIL reset_fpm_x: got %h exp 0", fpm_x); end
        total++; if (fpm_y !== 32'h0) begin bad++; $display("FAIL reset_fpm_y: got %h exp 0", fpm_y); end
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp: got %b exp 00", {rsp0_valid, rsp1_valid}); end
        total++; if (rsp_m !== 32'h0) begin bad++; $display("FAIL reset_rsp_m: got %h exp 0", rsp_m); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done: got %b exp 0", drain_done); end
        total++; if (issue_cnt0 !== '0 || issue_cnt1 !== '0) begin bad++; $display("FAIL reset_cnt: got %h/%h exp 0/0", issue_cnt0, issue_cnt1); end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_single();
        use_ovr = 1'b1; ovr_m = 32'h4000_0000;
        do_reset();
        req0_valid = 1'b1; req0_x = 32'h3F80_0000; req0_y = 32'h4000_0000;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single_grant: got %b exp 10", {req0_ready, req1_ready}); end
        total++; if (fpm_x !== 32'h3F80_0000 || fpm_y !== 32'h4000_0000) begin bad++; $display("FAIL single_ops: got %h %h exp 3f800000 40000000", fpm_x, fpm_y); end
        tick();
        idle();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++; if ({rsp0_valid, rsp1_valid} !== {(i == 3), 1'b0}) begin bad++; $display("FAIL single_rsp_t%0d: got %b exp %b", i, {rsp0_valid, rsp1_valid}, {(i == 3), 1'b0}); end
            total++; if (rsp_m !== ((i == 3) ? 32'h4000_0000 : 32'h0)) begin bad++; $display("FAIL single_rsp_m_t%0d: got %h", i, rsp_m); end
            tick();
        end
        total++; if (issue_cnt0 !== 16'd1 || issue_cnt1 !== 16'd0) begin bad++; $display("FAIL single_cnt: got %0d/%0d exp 1/0", issue_cnt0, issue_cnt1); end
        use_ovr = 1'b0;
    endtask

    task automatic test_contention();
        logic [31:0] em [0:5];
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            req0_valid = (i < 6); req1_valid = (i < 6);
            req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
            if (i < 6) em[i] = (i % 2 == 0) ? (req0_x ^ req0_y) : (req1_x ^ req1_y);
            @(negedge clk);
            if (i < 6) begin
                total++; if ({req0_ready, req1_ready} !== {(i % 2 == 0), (i % 2 == 1)}) begin bad++; $display("FAIL contention_grant_t%0d: got %b", i, {req0_ready, req1_ready}); end
            end
            if (i >= 3) begin
                total++; if ({rsp0_valid, rsp1_valid} !== {((i - 3) % 2 == 0), ((i - 3) % 2 == 1)}) begin bad++; $display("FAIL contention_rsp_t%0d: got %b", i, {rsp0_valid, rsp1_valid}); end
                total++; if (rsp_m !== em[i-3]) begin bad++; $display("FAIL contention_rsp_m_t%0d: got %h exp %h", i, rsp_m, em[i-3]); end
            end
            tick();
        end
        idle();
        total++; if (issue_cnt0 !== 16'd3 || issue_cnt1 !== 16'd3) begin bad++; $display("FAIL contention_cnt: got %0d/%0d exp 3/3", issue_cnt0, issue_cnt1); end
    endtask

    task automatic test_solo();
        do_reset();
        for (int i = 0; i <= 8; i++) begin
            req1_valid = (i < 5); req1_x = $urandom; req1_y = $urandom;
            @(negedge clk);
            if (i < 5) begin
                total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL solo_grant_t%0d: got %b exp 01", i, {req0_ready, req1_ready}); end
            end
            total++; if ({rsp0_valid, rsp1_valid} !== {1'b0, (i >= 3 && i < 8)}) begin bad++; $display("FAIL solo_rsp_t%0d: got %b", i, {rsp0_valid, rsp1_valid}); end
            tick();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL solo_rr_after: got %b exp 10", {req0_ready, req1_ready}); end
        tick();
        idle();
    endtask

    task automatic test_drain();
        do_reset();
        for (int i = 0; i <= 9; i++) begin
            req0_valid = (i < 2) || (i >= 2); req1_valid = (i >= 2);
            drain_req = (i >= 1 && i < 8);
            @(negedge clk);
            if (i < 2) begin
                total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL drain_grant_t%0d: got %b exp 1", i, req0_ready); end
            end else if (i < 9) begin
                total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL drain_nogrant_t%0d: got %b exp 00", i, {req0_ready, req1_ready}); end
            end else begin
                total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL drain_resume: got %b exp 01", {req0_ready, req1_ready}); end
            end
            if (i >= 2 && i <= 6) begin
                total++; if (rsp0_valid !== (i == 3 || i == 4)) begin bad++; $display("FAIL drain_rsp_t%0d: got %b", i, rsp0_valid); end
            end
            total++; if (drain_done !== (i >= 5 && i <= 8)) begin bad++; $display("FAIL drain_done_t%0d: got %b", i, drain_done); end
            tick();
        end
        idle();
        drain_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1'b1; req0_x = 32'hdead_beef; req0_y = 32'h1;
        @(negedge clk);
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL rmid_grant: got %b exp 1", req0_ready); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++; if (fpm_x !== 32'h0) begin bad++; $display("FAIL rmid_fpm_x: got %h exp 0", fpm_x); end
        total++; if (issue_cnt0 !== 16'd0) begin bad++; $display("FAIL rmid_cnt_during: got %0d exp 0", issue_cnt0); end
        tick();
        reset = 1'b0;
        idle();
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL rmid_rsp_t%0d: got %b exp 00", i, {rsp0_valid, rsp1_valid}); end
            tick();
        end
        total++; if (issue_cnt0 !== 16'd0 || issue_cnt1 !== 16'd0) begin bad++; $display("FAIL rmid_cnt: got %0d/%0d exp 0/0", issue_cnt0, issue_cnt1); end
    endtask

    task automatic test_wrap();
        do_reset();
        req0_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        total++; if (issue_cnt0 !== 16'hFFFF) begin bad++; $display("FAIL wrap_full: got %h exp ffff", issue_cnt0); end
        tick();
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        total++; if (issue_cnt0 !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h exp 0000", issue_cnt0); end
        total++; if (issue_cnt1 !== 16'h0000) begin bad++; $display("FAIL wrap_cnt1: got %h exp 0000", issue_cnt1); end
        tick();
    endtask

    // Reference: ops land in a response calendar LAT cycles ahead; drain state follows the calendar
    task automatic test_random();
        int          m_state;
        bit          m_rr;
        logic [15:0] m_c0, m_c1;
        bit          sv [16];
        bit          sid [16];
        logic [31:0] sm [16];
        int          cyc;
        bit          e0, e1, ev, pending;
        int          slot;
        logic [31:0] ex, ey, em;
        do_reset();
        m_state = 0; m_rr = 0; m_c0 = 0; m_c1 = 0; cyc = 0;
        for (int k = 0; k < 16; k++) begin sv[k] = 0; sid[k] = 0; sm[k] = 0; end
        for (int n = 0; n < 1500; n++) begin
            req0_valid = ($urandom_range(0, 3) != 0); req1_valid = ($urandom_range(0, 3) != 0);
            req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
            if ($urandom_range(0, 11) == 0) drain_req = ~drain_req;
            @(negedge clk);
            e0 = (m_state == 0) && req0_valid && (!req1_valid || !m_rr);
            e1 = (m_state == 0) && req1_valid && (!req0_valid || m_rr);
            ex = e0 ? req0_x : (e1 ? req1_x : 32'h0);
            ey = e0 ? req0_y : (e1 ? req1_y : 32'h0);
            slot = cyc % 16;
            ev = sv[slot];
            em = ev ? sm[slot] : 32'h0;
            total++; if ({req0_ready, req1_ready} !== {e0, e1}) begin bad++; $display("FAIL rand_grant c%0d: got %b exp %b", cyc, {req0_ready, req1_ready}, {e0, e1}); end
            total++; if (fpm_x !== ex || fpm_y !== ey) begin bad++; $display("FAIL rand_ops c%0d: got %h %h exp %h %h", cyc, fpm_x, fpm_y, ex, ey); end
            total++; if ({rsp0_valid, rsp1_valid} !== {ev && !sid[slot], ev && sid[slot]}) begin bad++; $display("FAIL rand_rsp c%0d: got %b exp %b", cyc, {rsp0_valid, rsp1_valid}, {ev && !sid[slot], ev && sid[slot]}); end
            total++; if (rsp_m !== em) begin bad++; $display("FAIL rand_rsp_m c%0d: got %h exp %h", cyc, rsp_m, em); end
            total++; if (drain_done !== (m_state == 2)) begin bad++; $display("FAIL rand_drain_done c%0d: got %b exp %b", cyc, drain_done, (m_state == 2)); end
            total++; if (issue_cnt0 !== m_c0 || issue_cnt1 !== m_c1) begin bad++; $display("FAIL rand_cnt c%0d: got %0d/%0d exp %0d/%0d", cyc, issue_cnt0, issue_cnt1, m_c0, m_c1); end
            sv[slot] = 0;
            if (e0 || e1) begin
                sv[(cyc + LAT) % 16]  = 1;
                sid[(cyc + LAT) % 16] = e1;
                sm[(cyc + LAT) % 16]  = ex ^ ey;
                m_rr = e0;
                if (e0) m_c0 = m_c0 + 1; else m_c1 = m_c1 + 1;
            end
            pending = 0;
            for (int k = 1; k <= LAT; k++) pending = pending | sv[(cyc + k) % 16];
            case (m_state)
                0: if (drain_req) m_state = 1;
                1: if (!pending) m_state = 2;
                default: if (!drain_req) m_state = 0;
            endcase
            cyc++;
            tick();
        end
        idle();
        drain_req = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_contention();
        test_solo();
        test_drain();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
